stats_collect_sat: RTL and testbench

Multi-channel statistics pre-accumulator with saturating sums, a programmable early-flush threshold, a per-channel enable mask and a flush-with-completion handshake. Sits between event sources (DMA engines, queue managers) and the shared statistics counter block. It folds many small per-cycle increments into fewer, wider stream updates tagged with the channel ID. It is a drop-in generalisation of the existing collector: with the default parameters and `stat_enable` all ones, its stream output matches the existing collector's output.

---
 rtl/stats_collect_pkg.sv | 19 +
 rtl/stats_collect_sat_if.sv | 13 +
 rtl/stats_acc_chan.sv | 33 +++
 rtl/stats_collect_sat.sv | 138 +++++++++++++
 tb/tb_stats_collect_sat.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stats_collect_pkg.sv
// Shared definitions for the statistics pre-accumulator: sweep FSM encoding and
// the saturating/wrapping adder used by both the channel accumulators and the sweep.
package stats_collect_pkg;

  localparam logic [0:0] STATE_READ  = 1'b0;
  localparam logic [0:0] STATE_WRITE = 1'b1;

  // Adds a and b, then clamps (sat=1) or wraps (sat=0) the result to width bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width, input bit sat);
    logic [63:0] max_v;
    logic [63:0] s;
    max_v = (64'd1 << width) - 64'd1;
    s     = a + b;
    if (sat && (s > max_v)) return max_v;
    return s & max_v;
  endfunction

endpackage

// File: rtl/stats_collect_sat_if.sv
// Stream interface carrying per-channel statistics updates (data, channel ID, valid/ready).
interface stats_collect_sat_if #(
  parameter int STAT_INC_WIDTH = 16,
  parameter int STAT_ID_WIDTH  = 3
);
  logic [STAT_INC_WIDTH-1:0] tdata;
  logic [STAT_ID_WIDTH-1:0]  tid;
  logic                      tvalid;
  logic                      tready;

  modport master (output tdata, output tid, output tvalid, input tready);
  modport slave  (input tdata, input tid, input tvalid, output tready);
endinterface

// File: rtl/stats_acc_chan.sv
// Single-channel increment accumulator; clear reloads with the current qualified
// increment so no count is lost on the cycle the sweep drains it.
module stats_acc_chan
  import stats_collect_pkg::*;
#(
  parameter int INC_WIDTH = 8,
  parameter int ACC_WIDTH = 12,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 valid,
  input  logic                 enable,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [INC_WIDTH-1:0] inc_q;

  assign inc_q = (valid && enable) ? inc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= ACC_WIDTH'(inc_q);
    end else begin
      acc <= ACC_WIDTH'(sat_add(64'(acc), 64'(inc_q), ACC_WIDTH, SATURATE != 0));
    end
  end

endmodule

// File: rtl/stats_collect_sat.sv
// Multi-channel statistics pre-accumulator: per-channel accumulators are swept
// round robin into stored sums, which are emitted on forced update, flush or early threshold.
//   state       | meaning
//   STATE_READ  | fetch mem[cnt] into rd
//   STATE_WRITE | fold acc[cnt] into the sum, emit or store it, advance cnt
module stats_collect_sat
  import stats_collect_pkg::*;
#(
  parameter int COUNT          = 8,
  parameter int INC_WIDTH      = 8,
  parameter int STAT_INC_WIDTH = 16,
  parameter int STAT_ID_WIDTH  = $clog2(COUNT),
  parameter int UPDATE_PERIOD  = 1024,
  parameter int FLUSH_BIT      = STAT_INC_WIDTH - 1,
  parameter int SATURATE       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INC_WIDTH*COUNT-1:0] stat_inc,
  input  logic [COUNT-1:0]           stat_valid,
  input  logic [COUNT-1:0]           stat_enable,
  stats_collect_sat_if.master        m_axis_stat,
  input  logic                       update,
  input  logic                       flush,
  output logic                       flush_done
);

  localparam int ACC_WIDTH = INC_WIDTH + $clog2(COUNT) + 1;
  localparam int PER_W     = $clog2(UPDATE_PERIOD);
  localparam logic [PER_W-1:0]         PER_RELOAD = PER_W'(UPDATE_PERIOD - 1);
  localparam logic [STAT_ID_WIDTH-1:0] CNT_LAST   = STAT_ID_WIDTH'(COUNT - 1);

  logic [ACC_WIDTH-1:0]      acc [COUNT];
  logic [COUNT-1:0]          acc_clear;
  logic [STAT_INC_WIDTH-1:0] mem [COUNT];
  logic [STAT_INC_WIDTH-1:0] rd;
  logic [STAT_INC_WIDTH-1:0] rd_eff;
  logic [STAT_INC_WIDTH-1:0] sum;
  logic [0:0]                state;
  logic [STAT_ID_WIDTH-1:0]  cnt;
  logic [PER_W-1:0]          per_cnt;
  logic [COUNT-1:0]          zero;
  logic [COUNT-1:0]          upd;
  logic                      flush_active;
  logic                      emit;
  logic                      period_hit;
  logic                      set_all;
  logic                      done_cond;
  logic [STAT_INC_WIDTH-1:0] tdata_q;
  logic [STAT_ID_WIDTH-1:0]  tid_q;
  logic                      tvalid_q;

  for (genvar n = 0; n < COUNT; n++) begin : g_chan
    stats_acc_chan #(
      .INC_WIDTH (INC_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .inc    (stat_inc[n*INC_WIDTH +: INC_WIDTH]),
      .valid  (stat_valid[n]),
      .enable (stat_enable[n]),
      .clear  (acc_clear[n]),
      .acc    (acc[n])
    );
  end

  always_comb begin
    acc_clear = '0;
    if (state == STATE_WRITE) acc_clear[cnt] = 1'b1;
  end

  // rd is unreset; the zero flag masks it, including for the early-flush bit.
  assign rd_eff     = zero[cnt] ? '0 : rd;
  assign sum        = STAT_INC_WIDTH'(sat_add(64'(rd_eff), 64'(acc[cnt]),
                                              STAT_INC_WIDTH, SATURATE != 0));
  assign emit       = (state == STATE_WRITE) && !tvalid_q && (upd[cnt] || rd_eff[FLUSH_BIT]);
  assign period_hit = (per_cnt == '0);
  assign set_all    = period_hit || update || flush;
  assign done_cond  = flush_active && (upd == '0) && !tvalid_q && !flush;

  assign m_axis_stat.tdata  = tdata_q;
  assign m_axis_stat.tid    = tid_q;
  assign m_axis_stat.tvalid = tvalid_q;

  always_ff @(posedge clk) begin
    if (state == STATE_READ) begin
      rd <= mem[cnt];
    end else begin
      mem[cnt] <= emit ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STATE_READ;
      cnt          <= '0;
      per_cnt      <= PER_RELOAD;
      zero         <= '1;
      upd          <= '0;
      flush_active <= 1'b0;
      flush_done   <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tid_q        <= '0;
    end else begin
      flush_done <= 1'b0;
      per_cnt    <= period_hit ? PER_RELOAD : per_cnt - 1'b1;
      if (tvalid_q && m_axis_stat.tready) tvalid_q <= 1'b0;

      if (state == STATE_READ) begin
        state <= STATE_WRITE;
      end else begin
        state     <= STATE_READ;
        cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        zero[cnt] <= 1'b0;
        if (emit) begin
          tdata_q  <= sum;
          tid_q    <= cnt;
          tvalid_q <= (sum != '0);
          upd[cnt] <= 1'b0;
        end
      end

      // A forced update in the same cycle wins over the per-channel clear.
      if (set_all) upd <= '1;

      if (flush) begin
        flush_active <= 1'b1;
      end else if (done_cond) begin
        flush_active <= 1'b0;
        flush_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stats_collect_sat.sv
// Self-checking bench for stats_collect_sat (COUNT=4): table vectors, directed
// corner sequences, and a randomized run checked against per-channel injected totals.
module tb_stats_collect_sat;

  localparam int COUNT = 4;
  localparam int IW    = 8;
  localparam int SW    = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [IW*COUNT-1:0]   stat_inc = '0;
  logic [COUNT-1:0]      stat_valid = '0;
  logic [COUNT-1:0]      stat_enable = '1;
  logic                  update = 1'b0;
  logic                  flush = 1'b0;
  logic                  flush_done;

  stats_collect_sat_if #(.STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(IDW)) s ();

  stats_collect_sat #(
    .COUNT(COUNT), .INC_WIDTH(IW), .STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(IDW),
    .UPDATE_PERIOD(1024), .FLUSH_BIT(15), .SATURATE(1)
  ) dut (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
    .stat_enable(stat_enable), .m_axis_stat(s), .update(update), .flush(flush),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tid;
    int data;
    int cyc;
  } beat_t;

  typedef struct {
    logic [3:0]          en;
    logic [3:0]          val;
    logic [3:0][7:0]     inc;
    int                  cycles;
    logic [3:0][15:0]    exp;
  } vec_t;

  beat_t beats[$];
  int    nchecks = 0;
  int    nerr = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_time = 0;
  logic  hold_pending = 1'b0;
  int    hold_data = 0;
  int    hold_tid = 0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && s.tvalid) begin
        check("stall_tdata_stable", int'(s.tdata), hold_data);
        check("stall_tid_stable", int'(s.tid), hold_tid);
      end
      hold_pending = s.tvalid && !s.tready;
      hold_data    = int'(s.tdata);
      hold_tid     = int'(s.tid);
      if (s.tvalid && s.tready) beats.push_back('{int'(s.tid), int'(s.tdata), cyc});
      if (flush_done) begin
        done_cnt++;
        done_time = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stat_valid = '0; stat_inc = '0; stat_enable = '1;
    update = 1'b0; flush = 1'b0; s.tready = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    beats.delete();
    done_cnt = 0;
  endtask

  function automatic int chan_sum(input int ch);
    int t = 0;
    foreach (beats[i]) if (beats[i].tid == ch) t += beats[i].data;
    return t;
  endfunction

  function automatic int chan_beats(input int ch);
    int t = 0;
    foreach (beats[i]) if (beats[i].tid == ch) t++;
    return t;
  endfunction

  task automatic pulse_update();
    update = 1'b1; tick(1); update = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit toggle);
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      if (toggle) s.tready = !s.tready;
      tick(1);
    end
    check("flush_done_seen", (done_cnt > 0) ? 1 : 0, 1);
  endtask

  vec_t vecs [3];
  int   model [COUNT];

  initial begin
    vecs[0] = '{4'b1111, 4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 10, {16'd0, 16'd50, 16'd0, 16'd0}};
    vecs[1] = '{4'b1011, 4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 20, {16'd20, 16'd0, 16'd20, 16'd20}};
    vecs[2] = '{4'b0110, 4'b1111, {8'd11, 8'd9, 8'd7, 8'd3}, 15, {16'd0, 16'd135, 16'd105, 16'd0}};

    // Reset state
    s.tready = 1'b1;
    tick(3);
    check("rst_tvalid", int'(s.tvalid), 0);
    check("rst_tdata", int'(s.tdata), 0);
    check("rst_tid", int'(s.tid), 0);
    check("rst_flush_done", int'(flush_done), 0);
    do_reset();

    // Table vectors: inject, pulse update, compare per-channel sums and beat counts
    for (int v = 0; v < 3; v++) begin
      do_reset();
      stat_enable = vecs[v].en;
      stat_valid  = vecs[v].val;
      stat_inc    = vecs[v].inc;
      tick(vecs[v].cycles);
      stat_valid = '0;
      pulse_update();
      tick(3 * COUNT + 4);
      for (int c = 0; c < COUNT; c++) begin
        check($sformatf("vec%0d_sum_ch%0d", v, c), chan_sum(c), int'(vecs[v].exp[c]));
        check($sformatf("vec%0d_beats_ch%0d", v, c), chan_beats(c), (vecs[v].exp[c] != 0) ? 1 : 0);
      end
    end

    // Early flush through the stored-sum threshold bit
    do_reset();
    stat_inc = {8'd0, 8'd0, 8'd0, 8'd255};
    stat_valid = 4'b0001;
    tick(300);
    stat_valid = '0;
    check("early_beat_present", (beats.size() > 0) ? 1 : 0, 1);
    if (beats.size() > 0) begin
      check("early_tid", beats[0].tid, 0);
      check("early_data_ge_8000", (beats[0].data >= 32768) ? 1 : 0, 1);
    end
    flush = 1'b1; tick(1); flush = 1'b0;
    wait_done(500, 1'b0);
    check("early_total", chan_sum(0), 300 * 255);

    // Randomized traffic against injected totals, then flush with toggling tready
    do_reset();
    for (int c = 0; c < COUNT; c++) model[c] = 0;
    for (int i = 0; i < 200; i++) begin
      stat_valid  = COUNT'($urandom);
      stat_enable = COUNT'($urandom);
      stat_inc    = $urandom;
      s.tready    = 1'($urandom);
      for (int c = 0; c < COUNT; c++)
        if (stat_valid[c] && stat_enable[c]) model[c] += int'(stat_inc[c*IW +: IW]);
      tick(1);
    end
    stat_valid = '0;
    flush = 1'b1; tick(1); flush = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      s.tready = !s.tready;
      tick(1);
    end
    check("reflush_no_early_done", done_cnt, 0);
    flush = 1'b1; s.tready = !s.tready; tick(1); flush = 1'b0;
    begin
      int f2 = cyc;
      wait_done(2000, 1'b1);
      check("reflush_delays_done", (done_time - f2 >= 2 * COUNT - 2) ? 1 : 0, 1);
    end
    if (beats.size() > 0)
      check("done_after_last_beat", (done_time > beats[beats.size()-1].cyc) ? 1 : 0, 1);
    for (int i = 0; i < 40; i++) begin
      s.tready = !s.tready;
      tick(1);
    end
    check("flush_done_once", done_cnt, 1);
    for (int c = 0; c < COUNT; c++)
      check($sformatf("rand_total_ch%0d", c), chan_sum(c), model[c]);
    s.tready = 1'b1;

    // Saturation of the stored sum under long backpressure
    do_reset();
    s.tready = 1'b0;
    stat_inc = {8'd0, 8'd0, 8'd255, 8'd0};
    stat_valid = 4'b0010;
    tick(1500);
    stat_valid = '0;
    s.tready = 1'b1;
    for (int i = 0; i < 200 && beats.size() < 2; i++) tick(1);
    check("sat_two_beats", (beats.size() >= 2) ? 1 : 0, 1);
    if (beats.size() >= 2) begin
      check("sat_first_tid", beats[0].tid, 1);
      check("sat_first_ge_8000", (beats[0].data >= 32768) ? 1 : 0, 1);
      check("sat_second_tid", beats[1].tid, 1);
      check("sat_second_data", beats[1].data, 65535);
    end

    // Reset mid-operation discards pending output and partial counts
    do_reset();
    s.tready = 1'b0;
    stat_inc = {8'd9, 8'd0, 8'd0, 8'd0};
    stat_valid = 4'b1000;
    tick(10);
    stat_valid = '0;
    pulse_update();
    for (int i = 0; i < 200 && !s.tvalid; i++) tick(1);
    check("mid_rst_pre_tvalid", int'(s.tvalid), 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid_cleared", int'(s.tvalid), 0);
    tick(1);
    beats.delete();
    s.tready = 1'b1;
    stat_inc = {8'd4, 8'd0, 8'd0, 8'd0};
    stat_valid = 4'b1000;
    tick(5);
    stat_valid = '0;
    pulse_update();
    tick(3 * COUNT + 4);
    check("post_rst_sum_ch3", chan_sum(3), 20);
    check("post_rst_beats_ch3", chan_beats(3), 1);
    check("post_rst_total_beats", beats.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
